rx_frame_ctrl: RTL
==================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 128, meaning maximum frame length in bits including CRC-16.
REQ-002 SHALL have parameter PRE_TIMEOUT, default 4096, meaning cycles to wait for a preamble after arming.
REQ-003 SHALL have parameter BIT_TIMEOUT, default 256, meaning maximum cycles between consecutive decoded bits.
REQ-004 SHALL have `clk  in  1`: the single clock; all logic is on its rising edge.
REQ-005 SHALL have `rst_n  in  1`: reset, asynchronous and active-low.
REQ-006 SHALL have `start  in  1`: one-cycle pulse that arms reception.
REQ-007 SHALL have `abort  in  1`: synchronous cancel.
REQ-008 SHALL have `cfg_len  in  $clog2(MAX_LEN+1)`: expected frame bit count, sampled on an accepted start.
REQ-009 SHALL have `cfg_crc_en  in  1`: enables the CRC check, sampled on an accepted start.
REQ-010 SHALL have `pre_det  in  1`: preamble-detected pulse from the preamble correlator.
REQ-011 SHALL have `bit_dat  in  1` and `bit_vld  in  1`: decoded bit and its valid strobe from the FM0 symbol decoder.
REQ-012 SHALL have `pre_en  out  1`: enables the preamble correlator.
REQ-013 SHALL have `sym_en  out  1` and `sym_rst  out  1`: symbol decoder enable, and a one-cycle decoder reset pulse.
REQ-014 SHALL have `frm_dat  out  1` and `frm_vld  out  1`: forwarded frame bits.
REQ-015 SHALL have `frm_done  out  1`, `frm_crc_ok  out  1`, `frm_timeout  out  1` and `busy  out  1`: frame status.

Function
REQ-016 SHALL implement FSM states IDLE, SEARCH, RECV and DONE; all outputs are registered.
REQ-017 In IDLE, start with cfg_len in 1..MAX_LEN SHALL latch cfg_len and cfg_crc_en and go to SEARCH; start with cfg_len=0 or cfg_len>MAX_LEN SHALL be ignored.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 pre_en SHALL be 1 exactly while the state is SEARCH; busy SHALL be 1 in SEARCH, RECV and DONE.
REQ-020 pre_det in SEARCH at cycle k SHALL cause, at cycle k+1: state RECV, sym_rst=1 for one cycle, sym_en=1, bit counter=0, CRC register=16'hFFFF.
REQ-021 pre_det outside SEARCH SHALL be ignored.
REQ-022 sym_en SHALL be 1 exactly while the state is RECV.
REQ-023 bit_vld outside RECV SHALL be ignored.
REQ-024 bit_vld in RECV at cycle k SHALL produce frm_vld=1 and frm_dat=bit_dat at k+1, increment the bit counter, and update the CRC.
REQ-025 CRC SHALL be CRC-16/CCITT: polynomial 0x1021, preset 0xFFFF, MSB-first serial, with fb = crc[15]^bit; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
REQ-026 Acceptance of the cfg_len-th bit at cycle k SHALL move to DONE at k+1, where frm_done=1 for one cycle alongside the final frm_vld; the next state is IDLE.
REQ-027 frm_crc_ok SHALL be set in DONE to (cfg_crc_en ? residue==16'h1D0F : 1), and held until the next accepted start, which clears it to 0.
REQ-028 A timeout counter SHALL clear on entry to SEARCH or RECV and on every accepted bit.
REQ-029 In SEARCH, reaching PRE_TIMEOUT-1 with no pre_det that cycle SHALL pulse frm_timeout for one cycle and go to IDLE.
REQ-030 In RECV, the same rule SHALL apply with BIT_TIMEOUT and bit_vld.
REQ-031 An event (pre_det or bit_vld) arriving in the cycle the timeout limit is reached SHALL win; no timeout fires.
REQ-032 abort SHALL force IDLE next cycle from any state, with no frm_done or frm_timeout, and has priority over all other inputs; a bit accepted in the abort cycle SHALL NOT be forwarded.
REQ-033 Timeout or abort SHALL leave frm_crc_ok=0.

Reset
REQ-034 While rst_n=0, the state SHALL be IDLE and all outputs, counters and latched configuration 0; the CRC register SHALL be 16'hFFFF.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no status pulse; operation resumes on the first start after rst_n rises.

Verification
REQ-036 Nominal: start, cfg_len=24, crc_en=1, then pre_det, then 8 data bits 8'hA5 followed by their CRC-16 -> 24 frm_vld pulses matching the input, frm_done 1 cycle after the last bit_vld, frm_crc_ok=1.
REQ-037 Corrupt frame: same as REQ-036 with one data bit flipped -> frm_done=1, frm_crc_ok=0; with crc_en=0 -> frm_crc_ok=1.
REQ-038 Search timeout: start, no pre_det for 4096 cycles -> frm_timeout pulse, busy=0, pre_en=0; pre_det on cycle 4095 instead -> RECV entered, no timeout.
REQ-039 Bit timeout: 5 bits, then a gap of 256 cycles -> frm_timeout, 5 frm_vld pulses only, no frm_done.
REQ-040 Ignored inputs: start during RECV, pre_det during RECV, and start with cfg_len=0 -> no state change, no extra sym_rst.
REQ-041 abort in the same cycle as the last bit_vld -> IDLE, no frm_done, no frm_vld for that bit; rst_n low mid-RECV -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: arms the preamble search, gates the FM0 symbol decoder,
// forwards decoded bits, counts the frame length and checks the CRC-16 residue.
module rx_frame_ctrl #(
  parameter int MAX_LEN     = 128,
  parameter int PRE_TIMEOUT = 4096,
  parameter int BIT_TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_crc_en,
  input  logic                         pre_det,
  input  logic                         bit_dat,
  input  logic                         bit_vld,
  output logic                         pre_en,
  output logic                         sym_en,
  output logic                         sym_rst,
  output logic                         frm_dat,
  output logic                         frm_vld,
  output logic                         frm_done,
  output logic                         frm_crc_ok,
  output logic                         frm_timeout,
  output logic                         busy
);

  localparam int LW   = $clog2(MAX_LEN+1);
  localparam int TMAX = (PRE_TIMEOUT > BIT_TIMEOUT) ? PRE_TIMEOUT : BIT_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] PRE_LIM     = TW'(PRE_TIMEOUT - 1);
  localparam logic [TW-1:0] BIT_LIM     = TW'(BIT_TIMEOUT - 1);
  localparam logic [LW-1:0] MAX_LEN_V   = LW'(MAX_LEN);
  localparam logic [15:0]   CRC_PRESET  = 16'hFFFF;
  localparam logic [15:0]   CRC_POLY    = 16'h1021;
  localparam logic [15:0]   CRC_RESIDUE = 16'h1D0F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RECV   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // One MSB-first serial step of CRC-16/CCITT.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  state_e        state_q;
  logic [LW-1:0] len_q;
  logic          crc_en_q;
  logic [LW-1:0] bit_cnt_q;
  logic [TW-1:0] tmo_q;
  logic [15:0]   crc_q;

  logic [15:0]   crc_nxt_s;
  logic [LW-1:0] bit_cnt_nxt_s;
  logic          cfg_ok_s;

  assign crc_nxt_s     = crc16_step(crc_q, bit_dat);
  assign bit_cnt_nxt_s = bit_cnt_q + LW'(1);
  assign cfg_ok_s      = (cfg_len != {LW{1'b0}}) && (cfg_len <= MAX_LEN_V);

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= {LW{1'b0}};
      crc_en_q    <= 1'b0;
      bit_cnt_q   <= {LW{1'b0}};
      tmo_q       <= {TW{1'b0}};
      crc_q       <= CRC_PRESET;
      pre_en      <= 1'b0;
      sym_en      <= 1'b0;
      sym_rst     <= 1'b0;
      frm_dat     <= 1'b0;
      frm_vld     <= 1'b0;
      frm_done    <= 1'b0;
      frm_crc_ok  <= 1'b0;
      frm_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sym_rst     <= 1'b0;
      frm_dat     <= 1'b0;
      frm_vld     <= 1'b0;
      frm_done    <= 1'b0;
      frm_timeout <= 1'b0;
      if (abort) begin
        // Cancel wins over every other input; any bit in this cycle is dropped.
        state_q    <= ST_IDLE;
        tmo_q      <= {TW{1'b0}};
        pre_en     <= 1'b0;
        sym_en     <= 1'b0;
        busy       <= 1'b0;
        frm_crc_ok <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && cfg_ok_s) begin
              state_q    <= ST_SEARCH;
              len_q      <= cfg_len;
              crc_en_q   <= cfg_crc_en;
              tmo_q      <= {TW{1'b0}};
              frm_crc_ok <= 1'b0;
              pre_en     <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_SEARCH: begin
            if (pre_det) begin
              state_q   <= ST_RECV;
              bit_cnt_q <= {LW{1'b0}};
              crc_q     <= CRC_PRESET;
              tmo_q     <= {TW{1'b0}};
              pre_en    <= 1'b0;
              sym_en    <= 1'b1;
              sym_rst   <= 1'b1;
            end else if (tmo_q == PRE_LIM) begin
              state_q     <= ST_IDLE;
              pre_en      <= 1'b0;
              busy        <= 1'b0;
              frm_timeout <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          ST_RECV: begin
            if (bit_vld) begin
              frm_vld   <= 1'b1;
              frm_dat   <= bit_dat;
              bit_cnt_q <= bit_cnt_nxt_s;
              crc_q     <= crc_nxt_s;
              tmo_q     <= {TW{1'b0}};
              if (bit_cnt_nxt_s == len_q) begin
                state_q    <= ST_DONE;
                sym_en     <= 1'b0;
                frm_done   <= 1'b1;
                frm_crc_ok <= crc_en_q ? (crc_nxt_s == CRC_RESIDUE) : 1'b1;
              end else begin
                state_q <= ST_RECV;
              end
            end else if (tmo_q == BIT_LIM) begin
              state_q     <= ST_IDLE;
              sym_en      <= 1'b0;
              busy        <= 1'b0;
              frm_timeout <= 1'b1;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            pre_en  <= 1'b0;
            sym_en  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
